// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache to main-memory arbiter.
package cache_arb_pkg;

    localparam int ARB_BLOCK_WORDS = 8;
    localparam int ARB_IDX_W       = $clog2(ARB_BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_mem_arbiter_block_fill_sequencer.sv
// Block-fill sequencer: one read address per cycle, counts returned words and
// flags the last one. Shared by the I and D fill states.
module block_fill_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              active,
    input  logic [ADDR_W-1:0] base,
    input  logic              mem_data_valid,
    output logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  word_idx,
    output logic              last
);

    localparam logic [IDX_W:0]   CNT_MAX  = BLOCK_WORDS[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    logic [IDX_W:0]   issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0] recv_cnt_q, recv_cnt_d;

    assign enable   = active && (issue_cnt_q < CNT_MAX);
    assign addr     = {base[ADDR_W-1:IDX_W+1], issue_cnt_q[IDX_W-1:0], 1'b0};
    assign word_idx = recv_cnt_q;
    assign last     = active && mem_data_valid && (recv_cnt_q == LAST_IDX);

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        if (start) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
        end else begin
            if (enable)
                issue_cnt_d = issue_cnt_q + 1'b1;
            // returns may overlap the issue phase
            if (active && mem_data_valid)
                recv_cnt_d = recv_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one pipelined main memory between I-cache fills and D-cache fills/writes.
// Optional ARB_ROUND_ROBIN_EN: alternate winner on simultaneous requests.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = ARB_BLOCK_WORDS,
    localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    output logic [DATA_W-1:0] i_data,
    output logic [IDX_W-1:0]  i_word_idx,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] d_data,
    output logic [IDX_W-1:0]  d_word_idx,
    output logic              d_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid
);

    arb_state_e        state_q, state_d;
    logic              i_grant_q, i_grant_d, d_grant_q, d_grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start, take_d, fill_active;
    logic              seq_en, seq_last;
    logic [ADDR_W-1:0] seq_addr;
    logic [IDX_W-1:0]  seq_idx;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q, last_owner_d;
`endif

    assign fill_active = (state_q == I_FILL) || (state_q == D_FILL);

    block_fill_sequencer #(
        .ADDR_W     (ADDR_W),
        .BLOCK_WORDS(BLOCK_WORDS),
        .IDX_W      (IDX_W)
    ) u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .active        (fill_active),
        .base          (base_q),
        .mem_data_valid(mem_data_valid),
        .enable        (seq_en),
        .addr          (seq_addr),
        .word_idx      (seq_idx),
        .last          (seq_last)
    );

    always_comb begin
        state_d   = state_q;
        i_grant_d = i_grant_q;
        d_grant_d = d_grant_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        start     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        take_d       = d_req && (!i_req || (last_owner_q == OWN_I));
`else
        take_d       = d_req;
`endif
        case (state_q)
            IDLE: begin
                if (take_d) begin
                    state_d   = d_wr ? D_WRITE : D_FILL;
                    d_grant_d = 1'b1;
                    base_d    = d_wr ? {d_addr[ADDR_W-1:1], 1'b0}
                                     : {d_addr[ADDR_W-1:IDX_W+1], {(IDX_W+1){1'b0}}};
                    wdata_d   = d_wdata;
                    start     = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_D;
`endif
                end else if (i_req) begin
                    state_d   = I_FILL;
                    i_grant_d = 1'b1;
                    base_d    = {i_addr[ADDR_W-1:IDX_W+1], {(IDX_W+1){1'b0}}};
                    start     = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_I;
`endif
                end
            end
            I_FILL: if (seq_last) begin
                state_d   = IDLE;
                i_grant_d = 1'b0;
            end
            D_FILL: if (seq_last) begin
                state_d   = IDLE;
                d_grant_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                d_grant_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        i_grant      = i_grant_q;
        d_grant      = d_grant_q;
        i_data_valid = (state_q == I_FILL) && mem_data_valid;
        d_data_valid = (state_q == D_FILL) && mem_data_valid;
        i_data       = i_data_valid ? mem_data_in : '0;
        d_data       = d_data_valid ? mem_data_in : '0;
        i_word_idx   = i_data_valid ? seq_idx : '0;
        d_word_idx   = d_data_valid ? seq_idx : '0;
        i_done       = (state_q == I_FILL) && seq_last;
        d_done       = ((state_q == D_FILL) && seq_last) || (state_q == D_WRITE);
        mem_enable   = seq_en || (state_q == D_WRITE);
        mem_wr       = (state_q == D_WRITE);
        mem_addr     = '0;
        mem_wdata    = '0;
        if (state_q == D_WRITE) begin
            mem_addr  = base_q;
            mem_wdata = wdata_q;
        end else if (seq_en) begin
            mem_addr  = seq_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_owner_q <= OWN_I;
        else        last_owner_q <= last_owner_d;
    end
`endif

endmodule
